alu_op_decode: RTL
==================

// Module: alu_op_decode
// PURPOSE
//  Decode/issue stage that drives the ALU's control and operand interface. Per RV32I instruction it
//  produces opsel, is_bne and both operands, held in a registered, single-entry valid/ready
//  pipeline slot between register read and execute. Pure RV32I, no CSR/system decode.
// PARAMETERS
//  RESET_PC_OPERAND  32'h0  value loaded into o_op1/o_op2 at reset (debug visibility only)
// PORTS
//  i_clk           in   1   clock, all state on rising edge
//  i_rst_n         in   1   asynchronous active-low reset
//  i_flush         in   1   synchronous kill of held and incoming instruction (branch redirect)
//  i_valid         in   1   upstream instruction/operands valid
//  o_ready         out  1   slot can accept this cycle
//  i_inst          in  32   instruction word
//  i_pc            in  32   instruction address
//  i_rs1_data      in  32   rs1 register value
//  i_rs2_data      in  32   rs2 register value
//  o_valid         out  1   decoded packet valid
//  i_ready         in   1   execute stage accepts packet
//  o_opsel         out  4   ALU op select (encoding below)
//  o_is_bne        out  1   BNE qualifier for opsel 4'b1001
//  o_op1           out 32   ALU operand 1
//  o_op2           out 32   ALU operand 2
//  o_is_branch     out  1   conditional branch: execute uses ALU jump condition
//  o_illegal       out  1   unsupported opcode/funct; packet still issues, opsel=add
// BEHAVIOUR
//  Reset (async, i_rst_n=0): o_valid=0, o_opsel=0, o_is_bne=0, o_is_branch=0, o_illegal=0,
//   o_op1=o_op2=RESET_PC_OPERAND. Deassertion takes effect on the next rising edge.
//  Handshake: o_ready = ~o_valid | i_ready (combinational, no dependence on i_valid).
//   Accept = i_valid & o_ready: all outputs load the decode of the inputs, o_valid<=1 next cycle.
//   Latency 1 cycle, throughput 1/cycle. o_valid & ~i_ready: all outputs held stable.
//   Packet retires on o_valid & i_ready. If there is no accept in the same cycle, o_valid<=0.
//   Outputs never change while o_valid & ~i_ready.
//  Flush: i_flush=1 forces o_valid<=0 and discards any same-cycle accept. Flush has priority
//   over both accept and hold. Data regs may update; only o_valid matters.
//  opsel encoding: 0000 add, 0001 sub, 0010 sll(reg), 0011 slli, 0100 slt/blt, 0101 bge,
//   0110 sltu/bltu, 0111 bgeu, 1000 xor, 1001 beq/bne, 1010 srl, 1011 sra, 1100 or,
//   1101 srli, 1110 and, 1111 srai.
//  Decode by opcode i_inst[6:0]. ImmI/S/B/U/J are sign-extended per the RV32I formats.
//   OP 0110011: op1=rs1, op2=rs2. f3 000: add, or sub if inst[30]=1. 001 sll, 010 slt,
//    011 sltu, 100 xor, 101: srl, or sra if inst[30]=1. 110 or, 111 and.
//    funct7 not in {0000000, 0100000}, or inst[30]=1 with f3 not in {000,101} -> illegal.
//   OP-IMM 0010011: op1=rs1, op2=ImmI. 000 add, 010 slt, 011 sltu, 100 xor, 110 or, 111 and,
//    001 slli (funct7 must be 0). 101: srli, or srai if inst[30]=1 (other funct7 -> illegal).
//   BRANCH 1100011: op1=rs1, op2=rs2, o_is_branch=1. 000 beq(is_bne=0), 001 bne(is_bne=1),
//    100 blt, 101 bge, 110 bltu, 111 bgeu. f3 010/011 -> illegal.
//   LOAD 0000011 / STORE 0100011: add, op1=rs1, op2=ImmI / ImmS (address generation).
//   LUI 0110111: add, op1=0, op2=ImmU.  AUIPC 0010111: add, op1=pc, op2=ImmU.
//   JAL 1101111 / JALR 1100111: add, op1=pc, op2=32'd4 (link value). Target computed elsewhere.
//   Any other opcode: illegal=1, opsel=add, op1=op2=0, is_branch=0.
//  o_is_bne=1 only for BNE. o_is_branch=0 for every non-BRANCH packet.
//  Arithmetic: no carries, 32-bit only. Shift amounts are passed whole; the ALU uses op2[4:0].
//  Reset mid-packet: packet lost, o_valid=0 immediately (asynchronous).
// TESTING
//  1 add x3,x1,x2, rs1=5, rs2=7, i_ready=1 -> next cycle o_valid=1, opsel=0000, op1=5, op2=7.
//  2 srai, inst=32'h4030_D093, rs1=32'h8000_0000 -> opsel=1111, op2[4:0]=3, illegal=0.
//  3 bne, f3=001, rs1=rs2=9 -> opsel=1001, is_bne=1, is_branch=1. beq -> is_bne=0.
//  4 Backpressure: i_ready=0 for 3 cycles with i_valid=1 held -> o_ready=0, outputs frozen.
//    i_ready=1 -> packet retires and the next packet loads the same cycle, no bubble.
//  5 i_flush with o_valid=1 and a same-cycle accept -> o_valid=0 next cycle, both packets dropped.
//  6 opcode 7'b1110011, auipc pc=32'h100 imm=0x1, async reset mid-stall ->
//    illegal=1; op1=32'h100, op2=32'h1000; o_valid=0 at once.

Source files
------------

// File: rtl/alu_op_decode_if.sv
// Handshake and data bundle between register read, the decode/issue slot and execute.
// The decoder sits on the slave modport; the producer/consumer pair drives the master side.
interface alu_op_decode_if;
    // Upstream side: instruction, operands and valid/ready toward register read
    logic        i_valid;
    logic        o_ready;
    logic [31:0] i_inst;
    logic [31:0] i_pc;
    logic [31:0] i_rs1_data;
    logic [31:0] i_rs2_data;

    // Downstream side: decoded packet and valid/ready toward execute
    logic        o_valid;
    logic        i_ready;
    logic [3:0]  o_opsel;
    logic        o_is_bne;
    logic [31:0] o_op1;
    logic [31:0] o_op2;
    logic        o_is_branch;
    logic        o_illegal;

    modport slave (
        input  i_valid,
        input  i_inst,
        input  i_pc,
        input  i_rs1_data,
        input  i_rs2_data,
        input  i_ready,
        output o_ready,
        output o_valid,
        output o_opsel,
        output o_is_bne,
        output o_op1,
        output o_op2,
        output o_is_branch,
        output o_illegal
    );

    modport master (
        output i_valid,
        output i_inst,
        output i_pc,
        output i_rs1_data,
        output i_rs2_data,
        output i_ready,
        input  o_ready,
        input  o_valid,
        input  o_opsel,
        input  o_is_bne,
        input  o_op1,
        input  o_op2,
        input  o_is_branch,
        input  o_illegal
    );
endinterface

// File: rtl/alu_op_decode.sv
// RV32I decode/issue slot: turns one instruction plus its register operands into ALU
// control (opsel, is_bne, is_branch, illegal) and the two ALU operands, held in a
// single registered valid/ready stage between register read and execute.
module alu_op_decode #(
    parameter logic [31:0] RESET_PC_OPERAND = 32'h0
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_flush,
    alu_op_decode_if.slave  bus
);

    // ALU op select encoding shared with execute
    typedef enum logic [3:0] {
        OPS_ADD  = 4'b0000,
        OPS_SUB  = 4'b0001,
        OPS_SLL  = 4'b0010,
        OPS_SLLI = 4'b0011,
        OPS_SLT  = 4'b0100,
        OPS_BGE  = 4'b0101,
        OPS_SLTU = 4'b0110,
        OPS_BGEU = 4'b0111,
        OPS_XOR  = 4'b1000,
        OPS_BEQ  = 4'b1001,
        OPS_SRL  = 4'b1010,
        OPS_SRA  = 4'b1011,
        OPS_OR   = 4'b1100,
        OPS_SRLI = 4'b1101,
        OPS_AND  = 4'b1110,
        OPS_SRAI = 4'b1111
    } opsel_e;

    // Major opcodes handled by this stage
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    // funct7 values that select the base and the alternate (sub/sra) form
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // Instruction fields
    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic [6:0]  w_funct7;
    logic [31:0] w_imm_i;
    logic [31:0] w_imm_s;
    logic [31:0] w_imm_u;

    assign w_opcode = bus.i_inst[6:0];
    assign w_funct3 = bus.i_inst[14:12];
    assign w_funct7 = bus.i_inst[31:25];
    assign w_imm_i  = {{20{bus.i_inst[31]}}, bus.i_inst[31:20]};
    assign w_imm_s  = {{20{bus.i_inst[31]}}, bus.i_inst[31:25], bus.i_inst[11:7]};
    assign w_imm_u  = {bus.i_inst[31:12], 12'h000};

    // Decoded packet for the instruction currently on the inputs
    opsel_e      w_opsel;
    logic        w_is_bne;
    logic        w_is_branch;
    logic        w_illegal;
    logic [31:0] w_op1;
    logic [31:0] w_op2;

    // Pipeline slot state
    logic        r_valid;
    logic [3:0]  r_opsel;
    logic        r_is_bne;
    logic        r_is_branch;
    logic        r_illegal;
    logic [31:0] r_op1;
    logic [31:0] r_op2;

    logic        w_ready;
    logic        w_accept;

    // The slot is free when empty or when its packet retires this cycle
    assign w_ready  = ~r_valid | bus.i_ready;
    assign w_accept = bus.i_valid & w_ready;

    // Combinational decode of opcode/funct into ALU control and operand selection
    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves a latch behind.
        w_opsel     = OPS_ADD;
        w_is_bne    = 1'b0;
        w_is_branch = 1'b0;
        w_illegal   = 1'b0;
        w_op1       = bus.i_rs1_data;
        w_op2       = bus.i_rs2_data;

        case (w_opcode)
            OPC_OP: begin
                case (w_funct3)
                    3'b000:  w_opsel = w_funct7[5] ? OPS_SUB : OPS_ADD;
                    3'b001:  w_opsel = OPS_SLL;
                    3'b010:  w_opsel = OPS_SLT;
                    3'b011:  w_opsel = OPS_SLTU;
                    3'b100:  w_opsel = OPS_XOR;
                    3'b101:  w_opsel = w_funct7[5] ? OPS_SRA : OPS_SRL;
                    3'b110:  w_opsel = OPS_OR;
                    default: w_opsel = OPS_AND;
                endcase
                // Only the base form, or the alternate form on add/srl, is RV32I
                if (!((w_funct7 == F7_BASE) ||
                      ((w_funct7 == F7_ALT) && ((w_funct3 == 3'b000) || (w_funct3 == 3'b101))))) begin
                    w_illegal = 1'b1;
                    w_opsel   = OPS_ADD;
                end
            end

            OPC_OP_IMM: begin
                w_op2 = w_imm_i;
                case (w_funct3)
                    3'b000:  w_opsel = OPS_ADD;
                    3'b001: begin
                        if (w_funct7 == F7_BASE) begin
                            w_opsel = OPS_SLLI;
                        end else begin
                            w_illegal = 1'b1;
                        end
                    end
                    3'b010:  w_opsel = OPS_SLT;
                    3'b011:  w_opsel = OPS_SLTU;
                    3'b100:  w_opsel = OPS_XOR;
                    3'b101: begin
                        if (w_funct7 == F7_BASE) begin
                            w_opsel = OPS_SRLI;
                        end else if (w_funct7 == F7_ALT) begin
                            w_opsel = OPS_SRAI;
                        end else begin
                            w_illegal = 1'b1;
                        end
                    end
                    3'b110:  w_opsel = OPS_OR;
                    default: w_opsel = OPS_AND;
                endcase
            end

            OPC_BRANCH: begin
                // An unsupported branch condition is issued as a plain add, never as a branch
                w_is_branch = 1'b1;
                case (w_funct3)
                    3'b000:  w_opsel = OPS_BEQ;
                    3'b001: begin
                        w_opsel  = OPS_BEQ;
                        w_is_bne = 1'b1;
                    end
                    3'b100:  w_opsel = OPS_SLT;
                    3'b101:  w_opsel = OPS_BGE;
                    3'b110:  w_opsel = OPS_SLTU;
                    3'b111:  w_opsel = OPS_BGEU;
                    default: begin
                        w_illegal   = 1'b1;
                        w_is_branch = 1'b0;
                    end
                endcase
            end

            // Loads and stores use the ALU for address generation only
            OPC_LOAD:  w_op2 = w_imm_i;
            OPC_STORE: w_op2 = w_imm_s;

            OPC_LUI: begin
                w_op1 = 32'h0;
                w_op2 = w_imm_u;
            end

            OPC_AUIPC: begin
                w_op1 = bus.i_pc;
                w_op2 = w_imm_u;
            end

            // Jumps produce the link value pc+4; the target is computed elsewhere
            OPC_JAL, OPC_JALR: begin
                w_op1 = bus.i_pc;
                w_op2 = 32'd4;
            end

            default: begin
                w_illegal = 1'b1;
                w_op1     = 32'h0;
                w_op2     = 32'h0;
            end
        endcase
    end

    // Valid/ready slot: flush kills, accept loads, retire empties, otherwise hold
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid     <= 1'b0;
            r_opsel     <= 4'b0000;
            r_is_bne    <= 1'b0;
            r_is_branch <= 1'b0;
            r_illegal   <= 1'b0;
            r_op1       <= RESET_PC_OPERAND;
            r_op2       <= RESET_PC_OPERAND;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            if (i_flush) begin
                r_valid <= 1'b0;
            end else if (w_accept) begin
                r_valid <= 1'b1;
            end else if (bus.i_ready) begin
                r_valid <= 1'b0;
            end

            // Data may load under flush; with o_valid low nobody looks at it
            if (w_accept) begin
                r_opsel     <= w_opsel;
                r_is_bne    <= w_is_bne;
                r_is_branch <= w_is_branch;
                r_illegal   <= w_illegal;
                r_op1       <= w_op1;
                r_op2       <= w_op2;
            end
        end
    end

    assign bus.o_ready     = w_ready;
    assign bus.o_valid     = r_valid;
    assign bus.o_opsel     = r_opsel;
    assign bus.o_is_bne    = r_is_bne;
    assign bus.o_is_branch = r_is_branch;
    assign bus.o_illegal   = r_illegal;
    assign bus.o_op1       = r_op1;
    assign bus.o_op2       = r_op2;

endmodule
